// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
//   Turns N raw asynchronous push-button levels into clean per-channel events
//   for a game controller. Each channel goes through a two-flop synchronizer
//   and a debounce counter. It then produces:
//     - a stable level,
//     - press and release strobes,
//     - a move strobe (out) that fires on the press and then auto-repeats
//       while the button is held.
//
// Ports
//   clk            in   1  rising-edge clock for all state
//   reset          in   1  asynchronous active-high reset, clears everything
//   button         in   N  raw button levels, 1 = pressed
//   repeat_en      in   1  global auto-repeat enable
//   level          out  N  debounced, registered level per channel
//   press          out  N  one-cycle pulse on a level 0->1 change
//   release_pulse  out  N  one-cycle pulse on a level 1->0 change
//                          (named this way because "release" is a reserved
//                          word in SystemVerilog)
//   out            out  N  press OR auto-repeat pulse per channel
// ----------------------------------------------------------------------------
module button_conditioner #(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_PERIOD   = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] button,
   input  logic         repeat_en,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   output logic [N-1:0] release_pulse,
   output logic [N-1:0] out
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX) + 1;

   localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RPT  = 2'd2
   } rpt_state_t;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_chan
         logic            sync1_reg, sync2_reg;
         logic            level_reg, level_next;
         logic            press_reg, press_next;
         logic            release_reg, release_next;
         logic            out_reg;
         logic            rpt_fire;
         logic [DW-1:0]   db_cnt_reg, db_cnt_next;
         logic [RW-1:0]   rpt_cnt_reg, rpt_cnt_next;
         rpt_state_t      state_reg, state_next;

         // Debounce: the counter measures how long the synchronized input has
         // disagreed with the accepted level. Once it has disagreed for
         // DEBOUNCE_CYCLES cycles, the new level is taken. The counter can
         // never climb past DB_LAST, so it cannot wrap.
         always_comb begin
            db_cnt_next  = db_cnt_reg;
            level_next   = level_reg;
            press_next   = 1'b0;
            release_next = 1'b0;
            if (sync2_reg == level_reg) begin
               db_cnt_next = '0;
            end else if (db_cnt_reg >= DB_LAST) begin
               db_cnt_next  = '0;
               level_next   = sync2_reg;
               press_next   = sync2_reg;
               release_next = ~sync2_reg;
            end else begin
               db_cnt_next = db_cnt_reg + DW'(1);
            end
         end

         // Auto-repeat FSM. It is driven by the same-edge press/release
         // decisions, so repeat pulses line up with the level change. Release
         // wins over a coincident repeat expiry.
         always_comb begin
            state_next   = state_reg;
            rpt_cnt_next = rpt_cnt_reg;
            rpt_fire     = 1'b0;
            if (release_next) begin
               state_next   = ST_IDLE;
               rpt_cnt_next = '0;
            end else begin
               case (state_reg)
                  ST_IDLE: begin
                     if (press_next) begin
                        state_next   = ST_WAIT;
                        rpt_cnt_next = '0;
                     end
                  end
                  ST_WAIT: begin
                     if (!repeat_en) begin
                        rpt_cnt_next = '0;
                     end else if (rpt_cnt_reg >= DELAY_LAST) begin
                        rpt_fire     = 1'b1;
                        state_next   = ST_RPT;
                        rpt_cnt_next = '0;
                     end else begin
                        rpt_cnt_next = rpt_cnt_reg + RW'(1);
                     end
                  end
                  ST_RPT: begin
                     // Disabling repeat falls back to WAIT, so re-enabling
                     // restarts the full initial delay.
                     if (!repeat_en) begin
                        state_next   = ST_WAIT;
                        rpt_cnt_next = '0;
                     end else if (rpt_cnt_reg >= PERIOD_LAST) begin
                        rpt_fire     = 1'b1;
                        rpt_cnt_next = '0;
                     end else begin
                        rpt_cnt_next = rpt_cnt_reg + RW'(1);
                     end
                  end
                  default: begin
                     state_next   = ST_IDLE;
                     rpt_cnt_next = '0;
                  end
               endcase
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync1_reg   <= 1'b0;
               sync2_reg   <= 1'b0;
               db_cnt_reg  <= '0;
               level_reg   <= 1'b0;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
               out_reg     <= 1'b0;
               rpt_cnt_reg <= '0;
               state_reg   <= ST_IDLE;
            end else begin
               sync1_reg   <= button[gi];
               sync2_reg   <= sync1_reg;
               db_cnt_reg  <= db_cnt_next;
               level_reg   <= level_next;
               press_reg   <= press_next;
               release_reg <= release_next;
               out_reg     <= press_next | rpt_fire;
               rpt_cnt_reg <= rpt_cnt_next;
               state_reg   <= state_next;
            end
         end

         assign level[gi]         = level_reg;
         assign press[gi]         = press_reg;
         assign release_pulse[gi] = release_reg;
         assign out[gi]           = out_reg;
      end
   endgenerate

endmodule
